axi4s_packet_fifo: RTL

//  Parametrised AXI4-Stream FIFO carrying TDATA/TKEEP/TLAST/TUSER with a registered master output.

---
 rtl/axi4s_packet_fifo.sv | 98 +++++++++
 1 files changed

// File: rtl/axi4s_packet_fifo.sv
// AXI4-Stream FIFO with registered master side, runtime cut-through / store-and-forward
// selection, fill level, almost-full flag and an oversize escape for packets larger than storage.
module axi4s_packet_fifo #(
    parameter int DATA_W    = 32,
    parameter int USER_W    = 1,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 12
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic                       i_pkt_mode,
    input  logic                       s_tvalid,
    output logic                       s_tready,
    input  logic [DATA_W-1:0]          s_tdata,
    input  logic [DATA_W/8-1:0]        s_tkeep,
    input  logic                       s_tlast,
    input  logic [USER_W-1:0]          s_tuser,
    output logic                       m_tvalid,
    input  logic                       m_tready,
    output logic [DATA_W-1:0]          m_tdata,
    output logic [DATA_W/8-1:0]        m_tkeep,
    output logic                       m_tlast,
    output logic [USER_W-1:0]          m_tuser,
    output logic [$clog2(DEPTH):0]     o_level,
    output logic                       o_almost_full,
    output logic                       o_oversize
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int KEEP_W = DATA_W / 8;
    localparam int ENT_W  = DATA_W + KEEP_W + 1 + USER_W;

    typedef logic [ADDR_W:0] ptr_t;

    logic [ENT_W-1:0] mem [DEPTH];
    logic [ENT_W-1:0] rd_ent;
    ptr_t             wr_ptr, cm_ptr, rd_ptr;
    ptr_t             wr_nxt, rd_nxt, lvl_nxt;
    logic             push, pop, full, ovs, ovr;

    assign o_level       = wr_ptr - rd_ptr;
    assign full          = (o_level == ptr_t'(DEPTH));
    assign o_almost_full = (o_level >= ptr_t'(AF_THRESH));
    assign push          = s_tvalid && s_tready;
    assign pop           = (!m_tvalid || m_tready) && (rd_ptr != cm_ptr);
    // Storage filled by a single uncommitted packet: release it or the FIFO deadlocks.
    assign ovs           = i_pkt_mode && full && (cm_ptr == rd_ptr) && !ovr;
    assign wr_nxt        = wr_ptr + ptr_t'(push);
    assign rd_nxt        = rd_ptr + ptr_t'(pop);
    assign lvl_nxt       = wr_nxt - rd_nxt;
    assign rd_ent        = mem[rd_ptr[ADDR_W-1:0]];

    always_ff @(posedge aclk) begin
        if (push)
            mem[wr_ptr[ADDR_W-1:0]] <= {s_tdata, s_tkeep, s_tlast, s_tuser};
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr     <= '0;
            cm_ptr     <= '0;
            rd_ptr     <= '0;
            s_tready   <= 1'b0;
            ovr        <= 1'b0;
            o_oversize <= 1'b0;
        end else begin
            wr_ptr     <= wr_nxt;
            rd_ptr     <= rd_nxt;
            s_tready   <= (lvl_nxt != ptr_t'(DEPTH));
            o_oversize <= ovs;
            // Commit includes this cycle's beat so cut-through latency stays at one edge.
            if (!i_pkt_mode || ovr || ovs || (push && s_tlast))
                cm_ptr <= wr_nxt;
            if (push && s_tlast)
                ovr <= 1'b0;
            else if (ovs)
                ovr <= 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            m_tkeep  <= '0;
            m_tlast  <= 1'b0;
            m_tuser  <= '0;
        end else if (pop) begin
            m_tvalid <= 1'b1;
            {m_tdata, m_tkeep, m_tlast, m_tuser} <= rd_ent;
        end else if (m_tready) begin
            m_tvalid <= 1'b0;
        end
    end

    mode_change_when_empty: assert property (
        @(posedge aclk) disable iff (!aresetn) !$stable(i_pkt_mode) |-> (o_level == '0));

endmodule
